// File: rtl/nonce_tx_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// nonce_tx_arbiter_pkg
// Shared definitions for the nonce transmit arbiter: FSM state encodings,
// nonce geometry and the byte/nonce typedefs used by the top and interface.
// No ports (package).
// ---------------------------------------------------------------------------
package nonce_tx_arbiter_pkg;

  localparam int NONCE_W         = 32;
  localparam int BYTES_PER_NONCE = 4;
  localparam int BYTE_IDX_W      = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_GUARD = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  typedef logic [NONCE_W-1:0] nonce_t;
  typedef logic [7:0]         byte_t;

endpackage

// File: rtl/nonce_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// nonce_tx_arbiter_if
// Bundles the nonce-source side and the UART-transmitter side of the
// arbiter into one interface.
//   in_nonce     : NUM_SRC packed 32-bit nonces, source i at [32i+31:32i]
//   in_valid     : per-source one-cycle capture pulse
//   tx_busy      : transmitter busy while shifting a byte
//   tx_byte      : byte presented to the transmitter
//   tx_new_byte  : one-cycle accept strobe for tx_byte
//   pending      : per-source holding-register-full flags
//   active       : a nonce is being sent
//   cur_src      : source being, or last, sent
//   overflow_cnt : saturating count of overwritten nonces
// Modports: master = producers/transmitter/observer, slave = arbiter.
// ---------------------------------------------------------------------------
interface nonce_tx_arbiter_if
  import nonce_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
);

  logic [NONCE_W*NUM_SRC-1:0] in_nonce;
  logic [NUM_SRC-1:0]         in_valid;
  logic                       tx_busy;
  logic [7:0]                 tx_byte;
  logic                       tx_new_byte;
  logic [NUM_SRC-1:0]         pending;
  logic                       active;
  logic [SRC_W-1:0]           cur_src;
  logic [7:0]                 overflow_cnt;

  modport master (
    output in_nonce, in_valid, tx_busy,
    input  tx_byte, tx_new_byte, pending, active, cur_src, overflow_cnt
  );

  modport slave (
    input  in_nonce, in_valid, tx_busy,
    output tx_byte, tx_new_byte, pending, active, cur_src, overflow_cnt
  );

endinterface

// File: rtl/nonce_tx_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches i_pending starting at
// i_ptr+1 and wrapping modulo NUM_SRC; the first set bit wins, so the
// source at i_ptr itself has the lowest priority.
//   i_pending : request vector
//   i_ptr     : index of the most recently granted source
//   o_win     : winning index (0 when nothing is pending)
//   o_found   : at least one request was set
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
) (
  input  logic [NUM_SRC-1:0] i_pending,
  input  logic [SRC_W-1:0]   i_ptr,
  output logic [SRC_W-1:0]   o_win,
  output logic               o_found
);

  // Walk distances from farthest to nearest so the nearest requester
  // (smallest offset past the pointer) is the final assignment.
  always_comb begin
    o_found = 1'b0;
    o_win   = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (i_pending[j] && (((int'(i_ptr) + k) % NUM_SRC) == j)) begin
          o_found = 1'b1;
          o_win   = SRC_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/nonce_tx_arbiter.sv
// ---------------------------------------------------------------------------
// nonce_tx_arbiter
// Shares one byte-wide serial transmitter between NUM_SRC nonce sources.
// Each source's nonce is captured into a holding register on its valid
// pulse; a round-robin grant copies one nonce into a shift register which
// is then issued MSB byte first through the tx_byte/tx_new_byte/tx_busy
// handshake.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : nonce_tx_arbiter_if.slave (sources, transmitter, status)
// ---------------------------------------------------------------------------
module nonce_tx_arbiter
  import nonce_tx_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
) (
  input  logic                clk,
  input  logic                reset,
  nonce_tx_arbiter_if.slave   bus
);

  nonce_t                r_hold [NUM_SRC];
  logic [NUM_SRC-1:0]    r_pending;
  logic [7:0]            r_ovf_cnt;

  logic [2:0]            r_state;
  logic [SRC_W-1:0]      r_ptr;
  logic [SRC_W-1:0]      r_cur_src;
  nonce_t                r_shift;
  logic [BYTE_IDX_W-1:0] r_byte_idx;
  byte_t                 r_tx_byte;
  logic                  r_tx_new;

  logic [SRC_W-1:0]      w_win;
  logic                  w_found;
  logic                  w_grant;
  nonce_t                w_win_data;
  logic [3:0]            w_ovf_num;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] n);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, n};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W)
  ) u_rr_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_win     (w_win),
    .o_found   (w_found)
  );

  assign w_grant = (r_state == ST_IDLE) && w_found;

  // Mux the winner's holding register without an out-of-range array index.
  always_comb begin
    w_win_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (w_win == SRC_W'(i)) w_win_data = r_hold[i];
    end
  end

  // A capture onto a full register is an overwrite, except on the source
  // being granted this cycle: its old value moves to the shift register,
  // so nothing is lost.
  always_comb begin
    w_ovf_num = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.in_valid[i] && r_pending[i] && !(w_grant && (w_win == SRC_W'(i))))
        w_ovf_num = w_ovf_num + 4'd1;
    end
  end

  // Capture stage: holding registers, pending flags, overflow counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
      r_ovf_cnt <= '0;
      for (int i = 0; i < NUM_SRC; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (bus.in_valid[i]) begin
          r_hold[i]    <= bus.in_nonce[NONCE_W*i +: NONCE_W];
          r_pending[i] <= 1'b1;
        end else if (w_grant && (w_win == SRC_W'(i))) begin
          r_pending[i] <= 1'b0;
        end
      end
      r_ovf_cnt <= sat_add8(r_ovf_cnt, w_ovf_num);
    end
  end

  // Transmit stage: grant, then issue four bytes through the handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_cur_src  <= '0;
      r_shift    <= '0;
      r_byte_idx <= '0;
      r_tx_byte  <= '0;
      r_tx_new   <= 1'b0;
    end else begin
      r_tx_new <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_shift   <= w_win_data;
            r_cur_src <= w_win;
            r_ptr     <= w_win;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_byte_idx <= '0;
          r_state    <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (!bus.tx_busy) begin
            r_tx_byte <= r_shift[NONCE_W-1 -: 8];
            r_tx_new  <= 1'b1;
            r_shift   <= {r_shift[NONCE_W-9:0], 8'h00};
            r_state   <= ST_GUARD;
          end
        end
        // The transmitter raises busy one cycle after the strobe; a busy
        // sample here would still be stale.
        ST_GUARD: begin
          r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!bus.tx_busy) begin
            if (r_byte_idx == BYTE_IDX_W'(BYTES_PER_NONCE-1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_byte_idx <= r_byte_idx + 1'b1;
              r_state    <= ST_ISSUE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_byte      = r_tx_byte;
  assign bus.tx_new_byte  = r_tx_new;
  assign bus.pending      = r_pending;
  assign bus.active       = (r_state != ST_IDLE);
  assign bus.cur_src      = r_cur_src;
  assign bus.overflow_cnt = r_ovf_cnt;

endmodule

// File: tb/tb_nonce_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nonce_tx_arbiter
// Directed bench for nonce_tx_arbiter with a behavioural transmitter that
// holds busy for a fixed number of cycles after each accepted byte and logs
// every byte together with cur_src at its strobe.
// ---------------------------------------------------------------------------
module tb_nonce_tx_arbiter;

  localparam int NUM_SRC = 4;
  localparam int SRC_W   = 3;

  logic clk;
  logic reset;

  nonce_tx_arbiter_if #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) bus ();

  nonce_tx_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]       rx_q[$];
  logic [SRC_W-1:0] src_q[$];
  int               busy_cnt   = 0;
  int               busy_len   = 10;
  logic             busy_stuck = 1'b0;

  // Transmitter model: accepts a byte on the strobe, then stays busy.
  always @(negedge clk) begin
    if (bus.tx_new_byte) begin
      rx_q.push_back(bus.tx_byte);
      src_q.push_back(bus.cur_src);
      busy_cnt = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt = busy_cnt - 1;
    end
    bus.tx_busy = busy_stuck || (busy_cnt > 0);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input int src, input logic [31:0] v);
    bus.in_nonce[32*src +: 32] = v;
    bus.in_valid               = '0;
    bus.in_valid[src]          = 1'b1;
    step();
    bus.in_valid = '0;
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int t;
    t = 0;
    while ((rx_q.size() < n) && (t < budget)) begin
      step();
      t++;
    end
    chk(tag, 64'(rx_q.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int t;
    t = 0;
    while (bus.active && (t < budget)) begin
      step();
      t++;
    end
    chk(tag, 64'(bus.active), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    chk("rst_active", 64'(bus.active), 64'd0);
    chk("rst_ovf", 64'(bus.overflow_cnt), 64'd0);
    rx_q.delete();
    src_q.delete();
    reset = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rx_word(input int k);
    return {rx_q[4*k], rx_q[4*k+1], rx_q[4*k+2], rx_q[4*k+3]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_nonce = '0;
    bus.in_valid = '0;
    step();
    step();

    // Reset state
    chk("reset_tx_byte", 64'(bus.tx_byte), 64'd0);
    chk("reset_tx_new", 64'(bus.tx_new_byte), 64'd0);
    chk("reset_pending", 64'(bus.pending), 64'd0);
    chk("reset_active", 64'(bus.active), 64'd0);
    chk("reset_cur_src", 64'(bus.cur_src), 64'd0);
    chk("reset_ovf", 64'(bus.overflow_cnt), 64'd0);
    reset = 1'b0;
    step();

    // Single nonce from source 2, latency to first strobe
    pulse(2, 32'hDEADBEEF);
    chk("single_pend_cap", 64'(bus.pending), 64'h4);
    chk("single_act_cap", 64'(bus.active), 64'd0);
    step();
    chk("single_pend_grant", 64'(bus.pending), 64'h0);
    chk("single_act_grant", 64'(bus.active), 64'd1);
    chk("single_cur_src", 64'(bus.cur_src), 64'd2);
    step();
    chk("single_no_strobe_load", 64'(bus.tx_new_byte), 64'd0);
    step();
    chk("single_strobe", 64'(bus.tx_new_byte), 64'd1);
    chk("single_byte0", 64'(bus.tx_byte), 64'hDE);
    wait_rx(4, 200, "single_nbytes");
    chk("single_word", 64'(rx_word(0)), 64'hDEADBEEF);
    chk("single_src", 64'(src_q[3]), 64'd2);
    wait_idle(100, "single_idle");
    repeat (20) step();
    chk("single_total", 64'(rx_q.size()), 64'd4);

    // Simultaneous capture on all sources
    do_reset();
    bus.in_nonce = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    bus.in_valid = 4'hF;
    step();
    bus.in_valid = '0;
    chk("sim_pending", 64'(bus.pending), 64'hF);
    wait_rx(16, 600, "sim_nbytes");
    chk("sim_w0", 64'(rx_word(0)), 64'h22222222);
    chk("sim_w1", 64'(rx_word(1)), 64'h33333333);
    chk("sim_w2", 64'(rx_word(2)), 64'h44444444);
    chk("sim_w3", 64'(rx_word(3)), 64'h11111111);
    chk("sim_src0", 64'(src_q[0]), 64'd1);
    chk("sim_src3", 64'(src_q[15]), 64'd0);
    chk("sim_ovf", 64'(bus.overflow_cnt), 64'd0);
    wait_idle(100, "sim_idle");
    repeat (20) step();
    chk("sim_total", 64'(rx_q.size()), 64'd16);

    // Overwrite of source 0 while source 1 transmits
    do_reset();
    pulse(1, 32'h12345678);
    wait_rx(1, 50, "ovw_first");
    pulse(0, 32'hAAAAAAAA);
    chk("ovw_ovf0", 64'(bus.overflow_cnt), 64'd0);
    repeat (3) step();
    pulse(0, 32'hBBBBBBBB);
    chk("ovw_ovf1", 64'(bus.overflow_cnt), 64'd1);
    wait_rx(8, 400, "ovw_nbytes");
    chk("ovw_w0", 64'(rx_word(0)), 64'h12345678);
    chk("ovw_w1", 64'(rx_word(1)), 64'hBBBBBBBB);
    chk("ovw_src", 64'(src_q[4]), 64'd0);
    wait_idle(100, "ovw_idle");
    repeat (20) step();
    chk("ovw_total", 64'(rx_q.size()), 64'd8);

    // Capture on the grant cycle of the same source
    do_reset();
    bus.in_nonce[96 +: 32] = 32'h01020304;
    bus.in_valid           = 4'b1000;
    step();
    bus.in_nonce[96 +: 32] = 32'h05060708;
    step();
    bus.in_valid = '0;
    chk("gc_pending", 64'(bus.pending), 64'h8);
    chk("gc_cur_src", 64'(bus.cur_src), 64'd3);
    chk("gc_ovf", 64'(bus.overflow_cnt), 64'd0);
    wait_rx(8, 400, "gc_nbytes");
    chk("gc_w0", 64'(rx_word(0)), 64'h01020304);
    chk("gc_w1", 64'(rx_word(1)), 64'h05060708);
    chk("gc_src", 64'(src_q[7]), 64'd3);
    chk("gc_ovf_end", 64'(bus.overflow_cnt), 64'd0);
    wait_idle(100, "gc_idle");

    // Reset after the second byte strobe
    do_reset();
    pulse(0, 32'hCAFEF00D);
    wait_rx(2, 100, "mid_nbytes");
    chk("mid_strobe_before", 64'(bus.tx_new_byte), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_tx_new", 64'(bus.tx_new_byte), 64'd0);
    chk("mid_tx_byte", 64'(bus.tx_byte), 64'd0);
    chk("mid_active", 64'(bus.active), 64'd0);
    chk("mid_cur_src", 64'(bus.cur_src), 64'd0);
    chk("mid_pending", 64'(bus.pending), 64'd0);
    step();
    step();
    reset = 1'b0;
    repeat (80) step();
    chk("mid_total", 64'(rx_q.size()), 64'd2);
    chk("mid_byte1", 64'(rx_q[1]), 64'hFE);
    chk("mid_idle", 64'(bus.active), 64'd0);

    // Saturation with the transmitter stuck busy
    busy_stuck = 1'b1;
    do_reset();
    for (int p = 1; p <= 305; p++) begin
      bus.in_nonce[0 +: 32] = 32'(p);
      bus.in_valid          = 4'b0001;
      step();
      bus.in_valid = '0;
      step();
      if (p == 200) chk("sat_200", 64'(bus.overflow_cnt), 64'd198);
      if (p == 300) chk("sat_300", 64'(bus.overflow_cnt), 64'd255);
    end
    chk("sat_305", 64'(bus.overflow_cnt), 64'd255);
    chk("sat_nobytes", 64'(rx_q.size()), 64'd0);
    chk("sat_active", 64'(bus.active), 64'd1);
    chk("sat_pending", 64'(bus.pending), 64'h1);
    busy_stuck = 1'b0;
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
